// File: rtl/sm_rom_loader.sv
// sm_rom_loader: unpacks a framed host byte stream into 32-bit instruction words,
// writes them into the node's instruction store and releases the core from reset
// once a complete, checksum-clean image has landed.
module sm_rom_loader #(
  parameter int unsigned SIZE    = 64,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned NODE_ID = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [7:0]        word_cnt
);

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] BCAST_NODE = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE, S_NODE, S_COUNT, S_DATA, S_WRITE, S_CSUM, S_SKIP
  } state_t;

  state_t              r_state,      w_state_nxt;
  logic                r_skip_frame, w_skip_frame_nxt;
  logic [7:0]          r_n,          w_n_nxt;
  logic [1:0]          r_byte_idx,   w_byte_idx_nxt;
  logic [7:0]          r_word_idx,   w_word_idx_nxt;
  logic [23:0]         r_word,       w_word_nxt;
  logic [7:0]          r_csum,       w_csum_nxt;
  logic                r_ovf,        w_ovf_nxt;
  logic [9:0]          r_skip_cnt,   w_skip_cnt_nxt;
  logic                r_in_ready,   w_in_ready_nxt;
  logic                r_mem_we,     w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr,   w_mem_addr_nxt;
  logic [31:0]         r_mem_wd,     w_mem_wd_nxt;
  logic                r_cpu_hold,   w_cpu_hold_nxt;
  logic                r_load_done,  w_load_done_nxt;
  logic                r_load_err,   w_load_err_nxt;
  logic [7:0]          r_word_cnt,   w_word_cnt_nxt;

  logic                w_acc;
  logic [31:0]         w_word_asm;
  logic                w_in_range;
  logic                w_node_hit;

  // Byte handshake, little-endian word assembly and store-range check.
  assign w_acc      = in_valid & r_in_ready;
  assign w_word_asm = {in_data, r_word};
  assign w_in_range = 32'(r_word_idx) < SIZE;
  assign w_node_hit = (in_data == 8'(NODE_ID)) || (in_data == BCAST_NODE);

  // Next-state and next-output logic for the frame parser.
  always_comb begin
    w_state_nxt      = r_state;
    w_skip_frame_nxt = r_skip_frame;
    w_n_nxt          = r_n;
    w_byte_idx_nxt   = r_byte_idx;
    w_word_idx_nxt   = r_word_idx;
    w_word_nxt       = r_word;
    w_csum_nxt       = r_csum;
    w_ovf_nxt        = r_ovf;
    w_skip_cnt_nxt   = r_skip_cnt;
    w_mem_we_nxt     = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wd_nxt     = r_mem_wd;
    w_cpu_hold_nxt   = r_cpu_hold;
    w_load_done_nxt  = 1'b0;
    w_load_err_nxt   = r_load_err;
    w_word_cnt_nxt   = r_word_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_acc && (in_data == SYNC_BYTE)) begin
          w_state_nxt    = S_NODE;
          w_load_err_nxt = 1'b0;
          w_word_cnt_nxt = 8'd0;
          w_csum_nxt     = 8'd0;
          w_ovf_nxt      = 1'b0;
        end
      end
      S_NODE: begin
        if (w_acc) begin
          w_skip_frame_nxt = !w_node_hit;
          w_state_nxt      = S_COUNT;
        end
      end
      S_COUNT: begin
        if (w_acc) begin
          w_n_nxt = in_data;
          if (r_skip_frame) begin
            // Foreign frame: 4N data bytes plus the checksum byte remain.
            w_skip_cnt_nxt = {in_data, 2'b01};
            w_state_nxt    = S_SKIP;
          end else begin
            w_cpu_hold_nxt = 1'b1;
            w_byte_idx_nxt = 2'd0;
            w_word_idx_nxt = 8'd0;
            w_state_nxt    = (in_data == 8'd0) ? S_CSUM : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_acc) begin
          w_word_nxt     = w_word_asm[31:8];
          w_csum_nxt     = r_csum ^ in_data;
          w_byte_idx_nxt = r_byte_idx + 2'd1;
          if (r_byte_idx == 2'd3) begin
            // Word complete: the write is issued while WRITE stalls the stream.
            w_state_nxt = S_WRITE;
            if (w_in_range) begin
              w_mem_we_nxt   = 1'b1;
              w_mem_addr_nxt = r_word_idx[ADDR_W-1:0];
              w_mem_wd_nxt   = w_word_asm;
              w_word_cnt_nxt = r_word_cnt + 8'd1;
            end else begin
              w_ovf_nxt = 1'b1;
            end
          end
        end
      end
      S_WRITE: begin
        w_word_idx_nxt = r_word_idx + 8'd1;
        w_state_nxt    = ((r_word_idx + 8'd1) < r_n) ? S_DATA : S_CSUM;
      end
      S_CSUM: begin
        if (w_acc) begin
          w_load_done_nxt = 1'b1;
          if ((in_data == r_csum) && !r_ovf) begin
            w_cpu_hold_nxt = 1'b0;
          end else begin
            w_load_err_nxt = 1'b1;
          end
          w_state_nxt = S_IDLE;
        end
      end
      S_SKIP: begin
        if (w_acc) begin
          w_skip_cnt_nxt = r_skip_cnt - 10'd1;
          if (r_skip_cnt == 10'd1) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_in_ready_nxt = (w_state_nxt != S_WRITE);
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_skip_frame <= 1'b0;
      r_n          <= 8'd0;
      r_byte_idx   <= 2'd0;
      r_word_idx   <= 8'd0;
      r_word       <= 24'd0;
      r_csum       <= 8'd0;
      r_ovf        <= 1'b0;
      r_skip_cnt   <= 10'd0;
      r_in_ready   <= 1'b1;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wd     <= 32'd0;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_word_cnt   <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_skip_frame <= w_skip_frame_nxt;
      r_n          <= w_n_nxt;
      r_byte_idx   <= w_byte_idx_nxt;
      r_word_idx   <= w_word_idx_nxt;
      r_word       <= w_word_nxt;
      r_csum       <= w_csum_nxt;
      r_ovf        <= w_ovf_nxt;
      r_skip_cnt   <= w_skip_cnt_nxt;
      r_in_ready   <= w_in_ready_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wd     <= w_mem_wd_nxt;
      r_cpu_hold   <= w_cpu_hold_nxt;
      r_load_done  <= w_load_done_nxt;
      r_load_err   <= w_load_err_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wd    = r_mem_wd;
  assign cpu_hold  = r_cpu_hold;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_sm_rom_loader.sv
// tb_sm_rom_loader: directed frames against a 64-word and a 4-word loader instance.
module tb_sm_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        sel;

  logic        b_valid, b_ready, b_we, b_hold, b_done, b_err;
  logic [5:0]  b_addr;
  logic [31:0] b_wd;
  logic [7:0]  b_wcnt;

  logic        s_valid, s_ready, s_we, s_hold, s_done, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wd;
  logic [7:0]  s_wcnt;

  logic        rdy;

  int n_total = 0;
  int n_bad   = 0;
  int stalls  = 0;

  int b_wr = 0, b_dn = 0, s_wr = 0, s_dn = 0;
  logic [5:0]  b_la [64];
  logic [31:0] b_ld [64];
  logic [1:0]  s_la [64];
  logic [31:0] s_ld [64];

  logic [7:0] fr[$];

  always #5 clk = ~clk;

  assign b_valid = in_valid & ~sel;
  assign s_valid = in_valid & sel;
  assign rdy     = sel ? s_ready : b_ready;

  sm_rom_loader #(.SIZE(64), .ADDR_W(6), .NODE_ID(0)) u_big (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(b_valid), .in_ready(b_ready),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wd(b_wd), .cpu_hold(b_hold),
    .load_done(b_done), .load_err(b_err), .word_cnt(b_wcnt)
  );

  sm_rom_loader #(.SIZE(4), .ADDR_W(2), .NODE_ID(0)) u_small (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(s_valid), .in_ready(s_ready),
    .mem_we(s_we), .mem_addr(s_addr), .mem_wd(s_wd), .cpu_hold(s_hold),
    .load_done(s_done), .load_err(s_err), .word_cnt(s_wcnt)
  );

  // Log every store write and count done pulses for both instances.
  always @(posedge clk) begin
    if (b_we) begin
      b_la[6'(b_wr)] <= b_addr;
      b_ld[6'(b_wr)] <= b_wd;
      b_wr <= b_wr + 1;
    end
    if (b_done) b_dn <= b_dn + 1;
    if (s_we) begin
      s_la[6'(s_wr)] <= s_addr;
      s_ld[6'(s_wr)] <= s_wd;
      s_wr <= s_wr + 1;
    end
    if (s_done) s_dn <= s_dn + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one byte from a negedge; returns on the negedge after it transferred.
  task automatic send(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (n >= 20) check("ready_timeout", n, 0);
    @(negedge clk);
  endtask

  task automatic send_fr();
    foreach (fr[i]) send(fr[i]);
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string p);
    check({p, "_ready"}, 32'(b_ready), 32'd1);
    check({p, "_we"},    32'(b_we),    32'd0);
    check({p, "_addr"},  32'(b_addr),  32'd0);
    check({p, "_wd"},    b_wd,         32'd0);
    check({p, "_hold"},  32'(b_hold),  32'd1);
    check({p, "_done"},  32'(b_done),  32'd0);
    check({p, "_err"},   32'(b_err),   32'd0);
    check({p, "_wcnt"},  32'(b_wcnt),  32'd0);
  endtask

  task automatic chk_frame1(input string p, input int base, input int dbase);
    check({p, "_nwr"},   b_wr - base, 2);
    check({p, "_a0"},    32'(b_la[6'(base)]), 32'd0);
    check({p, "_d0"},    b_ld[6'(base)], 32'h00500293);
    check({p, "_a1"},    32'(b_la[6'(base + 1)]), 32'd1);
    check({p, "_d1"},    b_ld[6'(base + 1)], 32'h005282B3);
    check({p, "_wcnt"},  32'(b_wcnt), 32'd2);
    check({p, "_ndone"}, b_dn - dbase, 1);
    check({p, "_hold"},  32'(b_hold), 32'd0);
    check({p, "_err"},   32'(b_err),  32'd0);
  endtask

  // Global time bound so a stuck handshake can never hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, dbase;
    in_valid = 1'b0;
    in_data  = 8'h00;
    sel      = 1'b0;
    rst      = 1'b1;
    #3;
    chk_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic two-word load.
    base = b_wr; dbase = b_dn;
    fr = '{8'hA5, 8'h00, 8'h02, 8'h93, 8'h02, 8'h50, 8'h00, 8'hB3, 8'h82, 8'h52, 8'h00, 8'hA2};
    send_fr();
    idle(2);
    chk_frame1("f1", base, dbase);

    // Foreign node frame is skipped (sync value inside payload), then a good frame loads.
    pulse_reset();
    base = b_wr; dbase = b_dn;
    fr = '{8'hA5, 8'h03, 8'h02, 8'h93, 8'hA5, 8'h50, 8'h00, 8'hB3, 8'h82, 8'h52, 8'h00, 8'h11};
    send_fr();
    idle(2);
    check("skip_nwr",   b_wr - base, 0);
    check("skip_ndone", b_dn - dbase, 0);
    check("skip_hold",  32'(b_hold), 32'd1);
    base = b_wr; dbase = b_dn;
    fr = '{8'hA5, 8'h00, 8'h02, 8'h93, 8'h02, 8'h50, 8'h00, 8'hB3, 8'h82, 8'h52, 8'h00, 8'hA2};
    send_fr();
    idle(2);
    chk_frame1("after_skip", base, dbase);

    // Broadcast frame with a corrupted checksum.
    base = b_wr; dbase = b_dn;
    fr = '{8'hA5, 8'hFF, 8'h01, 8'h63, 8'h00, 8'h00, 8'h00, 8'h00};
    send_fr();
    idle(2);
    check("bc_nwr",   b_wr - base, 1);
    check("bc_a0",    32'(b_la[6'(base)]), 32'd0);
    check("bc_d0",    b_ld[6'(base)], 32'h00000063);
    check("bc_err",   32'(b_err), 32'd1);
    check("bc_ndone", b_dn - dbase, 1);
    check("bc_hold",  32'(b_hold), 32'd1);
    send(8'hA5);
    check("sync_clears_err", 32'(b_err), 32'd0);
    dbase = b_dn;
    fr = '{8'h00, 8'h00, 8'h00};
    send_fr();
    idle(2);
    check("n0_ndone", b_dn - dbase, 1);
    check("n0_hold",  32'(b_hold), 32'd0);
    check("n0_err",   32'(b_err), 32'd0);
    check("n0_wcnt",  32'(b_wcnt), 32'd0);

    // Overflow on a 4-word store with a correct checksum.
    sel = 1'b1;
    base = s_wr; dbase = s_dn;
    fr = '{8'hA5, 8'h00, 8'h05};
    for (int k = 1; k <= 20; k++) fr.push_back(8'(k));
    fr.push_back(8'h14);
    send_fr();
    idle(2);
    check("ovf_nwr", s_wr - base, 4);
    check("ovf_a0",  32'(s_la[6'(base)]), 32'd0);
    check("ovf_d0",  s_ld[6'(base)], 32'h04030201);
    check("ovf_a1",  32'(s_la[6'(base + 1)]), 32'd1);
    check("ovf_d1",  s_ld[6'(base + 1)], 32'h08070605);
    check("ovf_a2",  32'(s_la[6'(base + 2)]), 32'd2);
    check("ovf_d2",  s_ld[6'(base + 2)], 32'h0C0B0A09);
    check("ovf_a3",  32'(s_la[6'(base + 3)]), 32'd3);
    check("ovf_d3",  s_ld[6'(base + 3)], 32'h100F0E0D);
    check("ovf_wcnt", 32'(s_wcnt), 32'd4);
    check("ovf_err",  32'(s_err), 32'd1);
    check("ovf_hold", 32'(s_hold), 32'd1);
    check("ovf_ndone", s_dn - dbase, 1);
    sel = 1'b0;

    // Continuous valid: one stall per word, exact byte order.
    base = b_wr; dbase = b_dn;
    fr = '{8'hA5, 8'h00, 8'h03, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01,
           8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hEB};
    stalls = 0;
    send_fr();
    check("bb_stalls", stalls, 3);
    idle(2);
    check("bb_nwr",  b_wr - base, 3);
    check("bb_a2",   32'(b_la[6'(base + 2)]), 32'd2);
    check("bb_d0",   b_ld[6'(base)], 32'hDEADBEEF);
    check("bb_d1",   b_ld[6'(base + 1)], 32'h01234567);
    check("bb_d2",   b_ld[6'(base + 2)], 32'hCAFEF00D);
    check("bb_wcnt", 32'(b_wcnt), 32'd3);
    check("bb_hold", 32'(b_hold), 32'd0);
    check("bb_ndone", b_dn - dbase, 1);

    // Asynchronous reset during the second word.
    base = b_wr;
    fr = '{8'hA5, 8'h00, 8'h02, 8'h93, 8'h02, 8'h50, 8'h00, 8'hB3, 8'h82};
    send_fr();
    in_valid = 1'b0;
    check("mid_wcnt", 32'(b_wcnt), 32'd1);
    check("mid_wd",   b_wd, 32'h00500293);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("async");
    check("async_nwr", b_wr - base, 1);
    check("async_d0",  b_ld[6'(base)], 32'h00500293);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = b_wr; dbase = b_dn;
    fr = '{8'hA5, 8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_fr();
    idle(2);
    check("rl_nwr",  b_wr - base, 1);
    check("rl_a0",   32'(b_la[6'(base)]), 32'd0);
    check("rl_d0",   b_ld[6'(base)], 32'h12345678);
    check("rl_hold", 32'(b_hold), 32'd0);
    check("rl_err",  32'(b_err), 32'd0);
    check("rl_ndone", b_dn - dbase, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
